// File: rtl/rom_fetch_sequencer.sv
// Multi-cycle fetch controller for a combinational instruction ROM.
// Jumps and halt resolve locally; everything else goes out over valid/ready.
module rom_fetch_sequencer #(
    parameter int unsigned        ADDR_W    = 10,
    parameter int unsigned        DATA_W    = 10,
    parameter logic [DATA_W-1:0]  HALT_WORD = 10'b0010000010,
    parameter logic [3:0]         JUMP_OP   = 4'b1000,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              ex_done,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [15:0]       ret_q, ret_d;
    logic [15:0]       ret_inc;

    assign ret_inc = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ret_d   = ret_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                instr_d = rom_data;
                // Halt wins over jump even if the encodings ever overlap.
                if (rom_data == HALT_WORD) begin
                    state_d = HALT;
                end else if (rom_data[DATA_W-1 -: 4] == JUMP_OP) begin
                    pc_d  = ADDR_W'(rom_data[5:0]);
                    ret_d = ret_inc;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) state_d = EXEC;
            end
            EXEC: begin
                if (ex_done) begin
                    pc_d    = redirect ? redirect_pc : pc_q + ADDR_W'(1);
                    ret_d   = ret_inc;
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    ret_d   = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign busy        = (state_q == FETCH) || (state_q == ISSUE) ||
                         (state_q == EXEC);
    assign retired     = ret_q;

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that drives the address of the 10-bit combinational instruction ROM.
- Holds the program counter and latches each instruction word.
- Resolves unconditional jumps and halt internally.
- Issues all other instructions to the datapath over a valid/ready handshake, then waits for execute completion and an optional branch redirect.

Parameters:
- ADDR_W, 10, program counter / ROM address width
- DATA_W, 10, instruction word width
- HALT_WORD, 10'b0010000010, encoding that stops the sequencer
- JUMP_OP, 4'b1000, value of instr[9:6] marking an unconditional jump
- RESET_PC, 0, start address after reset or restart

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin or restart execution; sampled only in IDLE and HALT
- rom_addr  output  ADDR_W  ROM read address; always equals pc
- rom_data  input  DATA_W  ROM read data; combinational from rom_addr
- instr  output  DATA_W  latched instruction word
- instr_valid  output  1  instr offered to the datapath
- instr_ready  input  1  datapath accepts instr
- ex_done  input  1  datapath finished executing the accepted instruction
- redirect  input  1  branch taken; qualified by ex_done
- redirect_pc  input  ADDR_W  branch target
- busy  output  1  high when state is not IDLE and not HALT
- halted  output  1  HALT_WORD fetched
- retired  output  16  count of completed instructions (jumps included, halt excluded)

Behaviour:
- States: IDLE, FETCH, ISSUE, EXEC, HALT.
- Reset (async, immediate, no clock needed):
  - state=IDLE, pc=RESET_PC, instr=0, retired=0
  - instr_valid=0, halted=0, busy=0
  - Reset mid-operation abandons any outstanding instruction; no handshake completes.
- IDLE:
  - start=1 -> FETCH. Otherwise hold.
- FETCH (one cycle):
  - instr <= rom_data.
  - If rom_data == HALT_WORD: -> HALT, halted=1; pc unchanged, retired unchanged, nothing issued.
  - Else if rom_data[9:6] == JUMP_OP: pc <= {0, rom_data[5:0]} (zero-extended), retired+1, remain in FETCH; instr_valid stays 0.
  - Otherwise: -> ISSUE, instr_valid=1.
  - HALT check has priority over the jump check.
- ISSUE:
  - instr_valid and instr are held stable until instr_ready=1.
  - On valid && ready: -> EXEC; instr_valid=0 from the next cycle.
- EXEC:
  - Wait for ex_done. ex_done outside EXEC is ignored, so ex_done in the same cycle as acceptance has no effect.
  - On ex_done: pc <= redirect ? redirect_pc : pc+1; retired+1; -> FETCH.
  - redirect without ex_done is ignored.
- HALT:
  - Hold all outputs.
  - start=1 -> pc=RESET_PC, retired=0, halted=0, -> FETCH.
- Arithmetic:
  - pc+1 wraps modulo 2^ADDR_W (0x3FF -> 0x000).
  - retired saturates at 0xFFFF.
- Timing:
  - Issued instruction: 3 cycles minimum (FETCH, ISSUE, EXEC), with instr_valid asserted 2 edges after the start edge.
  - Jump: 1 cycle.
  - A jump to its own address loops forever in FETCH (legal; busy=1).
- start while busy is ignored.

Test Plan:
- Reset, then ROM[0]=0110000001, ROM[1]=HALT_WORD; start pulse; ready=1; ex_done 1 cycle after acceptance -> instr=0x181 valid 2 edges after start; then halted=1, busy=0, retired=1, rom_addr=1.
- ROM[0]=1000000101 (jump 5), ROM[5]=0000101001 -> no instr_valid during the jump cycle; next issued instr=0x029 from rom_addr=5; retired=2 after its ex_done.
- Backpressure: instr_ready low for 5 cycles in ISSUE -> instr_valid=1 and instr constant for all 5; pc/state unchanged; acceptance on the 6th cycle.
- Redirect: ex_done=1, redirect=1, redirect_pc=0x3FE -> next rom_addr=0x3FE; after next ex_done with redirect=0 -> rom_addr=0x3FF, then 0x000.
- rst_n low mid-EXEC between clock edges -> instr_valid=0, busy=0, rom_addr=0, retired=0 immediately; a later ex_done pulse has no effect.
- In HALT with retired=3, pulse start -> retired=0, halted=0, fetch from address 0; start asserted while busy is ignored.
